// File: rtl/lsu_mem_master.sv
// Load/store master between the core's load/store decode and a word-organised
// data RAM. Byte, halfword and word accesses at byte addresses become word-port
// transactions; sub-word stores use read-modify-write. Little-endian lanes.
module lsu_mem_master #(
  parameter int WORD_WIDTH = 32,
  parameter int ENTRIES    = 100,
  parameter int ADDR_BITS  = $clog2(ENTRIES)
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Req,
  input  logic                  Wr,
  input  logic [1:0]            Size,
  input  logic                  Signed,
  input  logic [31:0]           Addr,
  input  logic [WORD_WIDTH-1:0] WData,
  output logic                  Ready,
  output logic                  Done,
  output logic                  Err,
  output logic [WORD_WIDTH-1:0] RData,
  output logic [ADDR_BITS-1:0]  Mem_A,
  output logic                  Mem_WE,
  output logic [WORD_WIDTH-1:0] Mem_WD,
  input  logic [WORD_WIDTH-1:0] Mem_RD
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t                state_r, state_next_s;
  logic [1:0]            size_r;
  logic                  signed_r;
  logic [ADDR_BITS-1:0]  idx_r;
  logic [1:0]            lane_r;
  logic [WORD_WIDTH-1:0] wdata_r;
  logic [WORD_WIDTH-1:0] merge_r;
  logic                  err_r;
  logic [WORD_WIDTH-1:0] rdata_r;
  logic                  accept_s;
  logic                  req_err_s;
  logic                  out_of_range_s;
  logic                  misaligned_s;

  // Select the addressed lane of a read word and zero/sign-extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic        sgn,
                                               input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   res = sgn ? {{24{b[7]}}, b} : {24'd0, b};
      2'b01:   res = sgn ? {{16{h[15]}}, h} : {16'd0, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace the addressed lane(s) of the old word with right-aligned store data.
  function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                              input logic [31:0] wd,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
    logic [31:0] res;
    res = old_word;
    case (size)
      2'b00: res[{lane, 3'b000} +: 8] = wd[7:0];
      2'b01: begin
        if (lane[1]) begin
          res[31:16] = wd[15:0];
        end else begin
          res[15:0] = wd[15:0];
        end
      end
      default: res = wd;
    endcase
    return res;
  endfunction

  assign accept_s = (state_r == IDLE) && Req;

  // Classify the incoming request as illegal, out of range or misaligned.
  always_comb begin
    out_of_range_s = (Addr[31:2] >= 30'(ENTRIES));
    misaligned_s   = 1'b0;
    case (Size)
      2'b01:   misaligned_s = Addr[0];
      2'b10:   misaligned_s = (Addr[1:0] != 2'b00);
      default: misaligned_s = 1'b0;
    endcase
    req_err_s = out_of_range_s | misaligned_s | (Size == 2'b11);
  end

  // State register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; the access path is chosen once at acceptance.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (Req) begin
          if (req_err_s) begin
            state_next_s = RESP;
          end else if (!Wr) begin
            state_next_s = LOAD;
          end else if (Size == 2'b10) begin
            state_next_s = WRITE;
          end else begin
            state_next_s = RMW_RD;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      LOAD:    state_next_s = RESP;
      RMW_RD:  state_next_s = WRITE;
      WRITE:   state_next_s = RESP;
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Latch request fields at acceptance so later input changes are ignored.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      size_r   <= 2'b00;
      signed_r <= 1'b0;
      idx_r    <= '0;
      lane_r   <= 2'b00;
      wdata_r  <= '0;
      err_r    <= 1'b0;
    end else if (accept_s) begin
      size_r   <= Size;
      signed_r <= Signed;
      idx_r    <= Addr[ADDR_BITS+1:2];
      lane_r   <= Addr[1:0];
      wdata_r  <= WData;
      err_r    <= req_err_s;
    end else begin
      err_r    <= err_r;
    end
  end

  // Capture the old RAM word for a sub-word read-modify-write.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      merge_r <= '0;
    end else if (state_r == RMW_RD) begin
      merge_r <= Mem_RD;
    end else begin
      merge_r <= merge_r;
    end
  end

  // Load result register; updated only when a load completes its read.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rdata_r <= '0;
    end else if (state_r == LOAD) begin
      rdata_r <= load_extract(Mem_RD, size_r, signed_r, lane_r);
    end else begin
      rdata_r <= rdata_r;
    end
  end

  // Decode handshake and RAM port outputs from the registered state.
  always_comb begin
    Ready  = 1'b0;
    Done   = 1'b0;
    Mem_A  = '0;
    Mem_WE = 1'b0;
    Mem_WD = '0;
    case (state_r)
      IDLE:   Ready = 1'b1;
      LOAD:   Mem_A = idx_r;
      RMW_RD: Mem_A = idx_r;
      WRITE: begin
        Mem_A  = idx_r;
        Mem_WE = 1'b1;
        if (size_r == 2'b10) begin
          Mem_WD = wdata_r;
        end else begin
          Mem_WD = store_merge(merge_r, wdata_r, size_r, lane_r);
        end
      end
      RESP:    Done = 1'b1;
      default: Ready = 1'b0;
    endcase
  end

  assign Err   = err_r;
  assign RData = rdata_r;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a behavioural word RAM and a
// scoreboard of expected completions.
module tb_lsu_mem_master;

  localparam int ENTRIES   = 100;
  localparam int ADDR_BITS = $clog2(ENTRIES);

  logic                 Clk = 1'b0;
  logic                 Rst = 1'b0;
  logic                 Req = 1'b0;
  logic                 Wr = 1'b0;
  logic [1:0]           Size = 2'b00;
  logic                 Signed = 1'b0;
  logic [31:0]          Addr = 32'd0;
  logic [31:0]          WData = 32'd0;
  logic                 Ready, Done, Err;
  logic [31:0]          RData;
  logic [ADDR_BITS-1:0] Mem_A;
  logic                 Mem_WE;
  logic [31:0]          Mem_WD;
  logic [31:0]          Mem_RD;

  logic [31:0] ram [ENTRIES];

  typedef struct {
    string       tag;
    logic        err;
    logic [31:0] rdata;
    int          cyc;
    int          we;
  } exp_t;

  exp_t sb[$];

  int passes = 0;
  int total  = 0;
  int we_cnt;
  int done_cyc;
  int ready_seen;
  logic [31:0] we_a, we_wd, a_c1;

  lsu_mem_master #(.WORD_WIDTH(32), .ENTRIES(ENTRIES)) dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .Wr(Wr), .Size(Size), .Signed(Signed),
    .Addr(Addr), .WData(WData), .Ready(Ready), .Done(Done), .Err(Err),
    .RData(RData), .Mem_A(Mem_A), .Mem_WE(Mem_WE), .Mem_WD(Mem_WD),
    .Mem_RD(Mem_RD)
  );

  always #5 Clk = ~Clk;

  // Behavioural RAM: clears on reset, writes on the clock edge.
  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < ENTRIES; i++) ram[i] <= 32'd0;
    end else if (Mem_WE && (int'(Mem_A) < ENTRIES)) begin
      ram[Mem_A] <= Mem_WD;
    end
  end

  assign Mem_RD = (int'(Mem_A) < ENTRIES) ? ram[Mem_A] : 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h required %h", tag, obs, exp);
  endtask

  task automatic push(input string tag, input logic err, input logic [31:0] rd,
                      input int cyc, input int we);
    exp_t e;
    e.tag = tag; e.err = err; e.rdata = rd; e.cyc = cyc; e.we = we;
    sb.push_back(e);
  endtask

  task automatic drive(input logic wr, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd);
    Req = 1'b1; Wr = wr; Size = size; Signed = sgn; Addr = addr; WData = wd;
  endtask

  // Wait (bounded) for Done after acceptance; optionally keep Req high.
  task automatic wait_done(input bit hold);
    we_cnt = 0; done_cyc = 0; ready_seen = 0; a_c1 = 32'd0;
    for (int c = 1; c <= 10 && done_cyc == 0; c++) begin
      @(negedge Clk);
      if (!hold) Req = 1'b0;
      if (c == 1) a_c1 = 32'(Mem_A);
      if (Ready) ready_seen++;
      if (Mem_WE) begin
        we_cnt++; we_a = 32'(Mem_A); we_wd = Mem_WD;
      end
      if (Done) done_cyc = c;
    end
  endtask

  task automatic check_resp();
    exp_t e;
    e = sb.pop_front();
    chk({e.tag, " done_cycle"}, 32'(done_cyc), 32'(e.cyc));
    chk({e.tag, " err"}, {31'd0, Err}, {31'd0, e.err});
    chk({e.tag, " rdata"}, RData, e.rdata);
    chk({e.tag, " we_count"}, 32'(we_cnt), 32'(e.we));
  endtask

  task automatic access(input string tag, input logic wr, input logic [1:0] size,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wd,
                        input logic exp_err, input logic [31:0] exp_rd,
                        input int exp_cyc, input int exp_we);
    @(negedge Clk);
    chk({tag, " ready_before"}, {31'd0, Ready}, 32'd1);
    push(tag, exp_err, exp_rd, exp_cyc, exp_we);
    drive(wr, size, sgn, addr, wd);
    @(posedge Clk);
    wait_done(1'b0);
    check_resp();
  endtask

  initial begin
    // Reset values while Rst is held low.
    @(negedge Clk);
    chk("rst ready", {31'd0, Ready}, 32'd1);
    chk("rst done", {31'd0, Done}, 32'd0);
    chk("rst err", {31'd0, Err}, 32'd0);
    chk("rst rdata", RData, 32'd0);
    chk("rst mem_a", 32'(Mem_A), 32'd0);
    chk("rst mem_we", {31'd0, Mem_WE}, 32'd0);
    chk("rst mem_wd", Mem_WD, 32'd0);
    @(negedge Clk);
    Rst = 1'b1;

    // Word store then loads of each lane shape.
    access("st_w", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0, 2, 1);
    chk("st_w mem_a", we_a, 32'd4);
    chk("st_w mem_wd", we_wd, 32'hDEADBEEF);
    access("ld_b_s", 1'b0, 2'b00, 1'b1, 32'h13, 32'd0, 1'b0, 32'hFFFFFFDE, 2, 0);
    access("ld_b_u", 1'b0, 2'b00, 1'b0, 32'h13, 32'd0, 1'b0, 32'h000000DE, 2, 0);
    access("ld_h_s", 1'b0, 2'b01, 1'b1, 32'h10, 32'd0, 1'b0, 32'hFFFFBEEF, 2, 0);
    access("ld_w", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b0, 32'hDEADBEEF, 2, 0);

    // Byte store via read-modify-write.
    access("st_b", 1'b1, 2'b00, 1'b0, 32'h11, 32'h123456AA, 1'b0, 32'hDEADBEEF, 3, 1);
    chk("st_b rmw_addr", a_c1, 32'd4);
    chk("st_b mem_wd", we_wd, 32'hDEADAAEF);
    access("ld_w2", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b0, 32'hDEADAAEF, 2, 0);

    // Rejected accesses: Done at cycle 1, Err, no write, RData held.
    access("err_mis", 1'b0, 2'b01, 1'b0, 32'h11, 32'd0, 1'b1, 32'hDEADAAEF, 1, 0);
    access("err_oor", 1'b1, 2'b10, 1'b0, 32'h190, 32'h55555555, 1'b1, 32'hDEADAAEF, 1, 0);
    access("err_sz", 1'b0, 2'b11, 1'b0, 32'h10, 32'd0, 1'b1, 32'hDEADAAEF, 1, 0);
    access("ld_last", 1'b0, 2'b10, 1'b0, 32'h18C, 32'd0, 1'b0, 32'd0, 2, 0);

    // Req held through a sub-word store, then a new request in the IDLE cycle.
    @(negedge Clk);
    push("hold_st", 1'b0, 32'd0, 3, 1);
    drive(1'b1, 2'b00, 1'b0, 32'h12, 32'h00000077);
    @(posedge Clk);
    wait_done(1'b1);
    drive(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
    check_resp();
    chk("hold_st busy_ready", 32'(ready_seen), 32'd0);
    chk("hold_st mem_wd", we_wd, 32'hDE77AAEF);
    @(negedge Clk);
    chk("hold idle_ready", {31'd0, Ready}, 32'd1);
    push("hold_ld", 1'b0, 32'hDE77AAEF, 2, 0);
    @(posedge Clk);
    wait_done(1'b0);
    check_resp();

    // Asynchronous reset in the middle of RMW_RD.
    @(negedge Clk);
    drive(1'b1, 2'b00, 1'b0, 32'h10, 32'h000000FF);
    @(posedge Clk);
    #2;
    chk("arst busy", {31'd0, Ready}, 32'd0);
    Rst = 1'b0;
    #1;
    chk("arst ready", {31'd0, Ready}, 32'd1);
    chk("arst mem_we", {31'd0, Mem_WE}, 32'd0);
    chk("arst done", {31'd0, Done}, 32'd0);
    Req = 1'b0;
    done_cyc = 0; we_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk);
      if (c == 1) Rst = 1'b1;
      if (Done) done_cyc++;
      if (Mem_WE) we_cnt++;
    end
    chk("arst no_done", 32'(done_cyc), 32'd0);
    chk("arst no_write", 32'(we_cnt), 32'd0);
    access("arst_ld", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b0, 32'd0, 2, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
# lsu_mem_master

Load/store master for the single-cycle MIPS data path. It sits between the core's load/store decode and the word-organised data RAM: it drives the RAM address, write-enable and write-data port and consumes its combinational read data. It turns byte, halfword and word accesses at byte addresses into word-port transactions, doing read-modify-write for sub-word stores. It reports completion and errors back to the core.

## Interface

Parameters:
- WORD_WIDTH, 32, data word width. Fixed at 32; four byte lanes.
- ENTRIES, 100, number of RAM words.
- ADDR_BITS, $clog2(ENTRIES), width of the RAM word address.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Req  in  1  access request, sampled only while Ready=1.
- Wr  in  1  1 = store, 0 = load.
- Size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal (error).
- Signed  in  1  for loads, sign-extend byte or halfword; ignored for word loads and stores.
- Addr  in  32  byte address.
- WData  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- Ready  out  1  idle; a request is accepted this cycle if Req=1.
- Done  out  1  one-cycle completion pulse.
- Err  out  1  valid with Done: access rejected, no RAM write.
- RData  out  32  load result. Updated at load completion, held otherwise.
- Mem_A  out  ADDR_BITS  RAM word address.
- Mem_WE  out  1  RAM write enable.
- Mem_WD  out  32  RAM write data.
- Mem_RD  in  32  RAM read data (combinational from Mem_A).

## Operation

- Byte order is little-endian: byte k of a word occupies bits [8k+7:8k], with k = Addr[1:0].
- The word index is Addr[ADDR_BITS+1:2].
- Out of range: Addr[31:2] >= ENTRIES.
- Misaligned: a halfword with Addr[0]=1, or a word with Addr[1:0]!=0.
- The request fields (Wr, Size, Signed, Addr, WData) are latched at acceptance. Later input changes have no effect.

State machine, states IDLE, LOAD, RMW_RD, WRITE, RESP:
- IDLE: Ready=1. On Req=1:
  - error (out of range, misaligned or Size=11) → RESP with Err=1;
  - load → LOAD;
  - word store → WRITE;
  - byte or halfword store → RMW_RD.
- LOAD: Mem_A = index. Extract the addressed lane from Mem_RD, zero- or sign-extend it, and register it into RData at the clock edge. Next state RESP.
- RMW_RD: Mem_A = index. Capture Mem_RD into the merge register. Next state WRITE.
- WRITE: Mem_A = index, Mem_WE=1.
  - Word store: Mem_WD = WData.
  - Sub-word store: Mem_WD = merge word with the addressed lane(s) replaced by WData[7:0] or WData[15:0].
  - The RAM writes at the end of this cycle. Next state RESP.
- RESP: Done=1 and Err valid. Next state IDLE.

Other rules:
- Outputs in IDLE: Mem_A=0, Mem_WE=0, Mem_WD=0.
- Mem_WE is 1 only in WRITE and never on an errored access.
- Req while Ready=0 is ignored; there is no queueing. The requester re-issues after Done.
- Err and RData are not cleared between accesses. Err is meaningful only while Done=1.

## Timing

- Acceptance happens at the clock edge where Ready=1 and Req=1 (edge 0).
- Done is high during cycle:
  - 1 for an errored access;
  - 2 for a load or word store;
  - 3 for a sub-word store.
- RData is valid in the Done cycle and holds until the next load completes.
- Back-to-back: Ready returns one cycle after Done. Minimum request spacing is 3 cycles for a load or word store and 4 for a sub-word store.
- Reset values: state IDLE, Ready=1, Done=0, Err=0, RData=0, Mem_A=0, Mem_WE=0, Mem_WD=0.
- Reset is asynchronous. Assertion mid-operation forces these values immediately, abandons the access, produces no Done, and drops Mem_WE at once. The RAM shares Rst and clears itself.

## Test plan

- Reset, then word store Addr=0x10, WData=0xDEADBEEF → Mem_WE high for exactly one cycle with Mem_A=4, Mem_WD=0xDEADBEEF; Done at cycle 2, Err=0.
- Loads after the store above:
  - byte Addr=0x13 signed → RData=0xFFFFFFDE;
  - byte Addr=0x13 unsigned → 0x000000DE;
  - half Addr=0x10 signed → 0xFFFFBEEF;
  - word Addr=0x10 → 0xDEADBEEF.
  - Each has Done at cycle 2.
- Byte store Addr=0x11, WData=0x123456AA → RMW_RD reads 0xDEADBEEF, WRITE drives Mem_WD=0xDEADAAEF, Done at cycle 3. A word load then returns 0xDEADAAEF.
- Error accesses:
  - half load Addr=0x11 → Done and Err=1 at cycle 1, RData unchanged, Mem_WE never high;
  - word store Addr=0x190 (index 100) → Err=1, no write;
  - Size=11 → Err=1.
- Req held high during a sub-word store → no second acceptance until Ready returns. A new request issued in the IDLE cycle after Done is accepted.
- Rst asserted during RMW_RD of a byte store → Ready=1, Mem_WE=0 and Done=0 immediately. After release, a load of word 4 returns 0x00000000.
